load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the controller (master) and the load/store unit (slave).
interface load_store_unit_if #(
    parameter int AW = 4,
    parameter int DW = 4,
    parameter int RW = 2
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [RW-1:0] req_reg;

    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [RW-1:0] resp_reg;
    logic          resp_wb;
    logic          resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_reg, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_reg, resp_wb, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_reg, resp_ready,
        output req_ready, resp_valid, resp_data, resp_reg, resp_wb, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store/rmw-add sequencer in front of a registered-read data_memory.
// Optional last-write forwarding for loads is enabled with `define LSU_FWD_EN.
module load_store_unit #(
    parameter int AW = 4,
    parameter int DW = 4,
    parameter int RW = 2
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic [AW-1:0]       M_add,
    output logic                M_we,
    output logic                M_re,
    output logic [DW-1:0]       M_wd,
    input  logic [DW-1:0]       M_rd
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        RESP
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    op_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [RW-1:0] dest_reg;
    logic [DW-1:0] rdata_reg;
    logic          err_reg;
    logic          fwd_hit;

`ifdef LSU_FWD_EN
    logic          fwd_v_reg;
    logic [AW-1:0] fwd_addr_reg;
    logic [DW-1:0] fwd_data_reg;

    assign fwd_hit = fwd_v_reg && (bus.req_op == OP_LOAD) && (bus.req_addr == fwd_addr_reg);

    // Tracks the most recent memory write so a matching load can skip the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_v_reg    <= 1'b0;
            fwd_addr_reg <= '0;
            fwd_data_reg <= '0;
        end else if (state_reg == WR_ISSUE) begin
            fwd_v_reg    <= 1'b1;
            fwd_addr_reg <= addr_reg;
            fwd_data_reg <= wdata_reg;
        end
    end
`else
    assign fwd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            dest_reg  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_reg    <= bus.req_op;
                        addr_reg  <= bus.req_addr;
                        wdata_reg <= bus.req_wdata;
                        dest_reg  <= bus.req_reg;
                        err_reg   <= (bus.req_op == 2'b11);
                        rdata_reg <= '0;
`ifdef LSU_FWD_EN
                        if (fwd_hit)
                            rdata_reg <= fwd_data_reg;
`endif
                    end
                end
                RD_CAPTURE: begin
                    rdata_reg <= M_rd;
                    // Carry out of the add is intentionally dropped.
                    if (op_reg == OP_RMW)
                        wdata_reg <= M_rd + wdata_reg;
                end
                default: ;
            endcase
        end
    end

    assign M_add = addr_reg;

    always_comb begin
        state_next     = state_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.resp_reg   = '0;
        bus.resp_wb    = 1'b0;
        bus.resp_err   = 1'b0;
        M_re           = 1'b0;
        M_we           = 1'b0;
        M_wd           = '0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_LOAD:  state_next = fwd_hit ? RESP : RD_ISSUE;
                        OP_STORE: state_next = WR_ISSUE;
                        OP_RMW:   state_next = RD_ISSUE;
                        default:  state_next = RESP;
                    endcase
                end
            end
            RD_ISSUE: begin
                M_re       = 1'b1;
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                state_next = (op_reg == OP_RMW) ? WR_ISSUE : RESP;
            end
            WR_ISSUE: begin
                M_we       = 1'b1;
                M_wd       = wdata_reg;
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_reg   = dest_reg;
                bus.resp_err   = err_reg;
                bus.resp_wb    = (op_reg == OP_LOAD) || (op_reg == OP_RMW);
                bus.resp_data  = bus.resp_wb ? rdata_reg : '0;
                if (bus.resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a behavioural registered-read data_memory.
module tb_load_store_unit;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int RW = 2;
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.AW(AW), .DW(DW), .RW(RW)) bus();
    logic [AW-1:0] M_add;
    logic          M_we;
    logic          M_re;
    logic [DW-1:0] M_wd;
    logic [DW-1:0] M_rd;

    load_store_unit #(.AW(AW), .DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .M_add (M_add),
        .M_we  (M_we),
        .M_re  (M_re),
        .M_wd  (M_wd),
        .M_rd  (M_rd)
    );

    function automatic logic [DW-1:0] mem_init(input int a);
        return (a == 2) ? 4'd5 : 4'(a);
    endfunction

    logic [DW-1:0] mem [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
            M_rd <= '0;
        end else begin
            if (M_we) mem[M_add] <= M_wd;
            if (M_re) M_rd <= mem[M_add];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rg;
        logic          wb;
        logic          err;
        int            lat;
        int            re;
        int            we;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] ref_mem [16];
`ifdef LSU_FWD_EN
    logic          fwd_v;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
`endif

    int            re_cnt = 0;
    int            we_cnt = 0;
    logic [AW-1:0] last_re_add = '0;
    logic [AW-1:0] last_we_add = '0;
    logic [DW-1:0] last_we_wd = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (M_re) begin re_cnt++; last_re_add = M_add; end
                if (M_we) begin we_cnt++; last_we_add = M_add; last_we_wd = M_wd; end
                total++;
                if ((M_re && M_we) || (!M_we && M_wd !== '0)) begin
                    bad++;
                    $display("FAIL strobe_rules got we=%b re=%b wd=%h required exclusive strobes and wd=0 when idle", M_we, M_re, M_wd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
`ifdef LSU_FWD_EN
        fwd_v = 1'b0; fwd_addr = '0; fwd_data = '0;
`endif
    endtask

    // Computes the expected response, pushes it, then drives the request until accepted.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [RW-1:0] rg, output int waited);
        exp_t          e;
        logic          hit;
        logic [DW-1:0] hit_data;
        hit = 1'b0; hit_data = '0;
`ifdef LSU_FWD_EN
        if (fwd_v && fwd_addr == addr) begin hit = 1'b1; hit_data = fwd_data; end
`endif
        e.rg = rg; e.err = 1'b0; e.data = '0; e.wb = 1'b0; e.re = 0; e.we = 0; e.lat = 1;
        case (op)
            OP_LD: begin
                e.wb = 1'b1;
                if (hit) begin e.data = hit_data; e.lat = 1; end
                else begin e.data = ref_mem[addr]; e.lat = 3; e.re = 1; end
            end
            OP_ST: begin
                e.lat = 2; e.we = 1; ref_mem[addr] = wd;
            end
            OP_RMW: begin
                e.data = ref_mem[addr]; e.wb = 1'b1; e.lat = 4; e.re = 1; e.we = 1;
                ref_mem[addr] = ref_mem[addr] + wd;
            end
            default: begin
                e.err = 1'b1; e.lat = 1;
            end
        endcase
`ifdef LSU_FWD_EN
        if (op == OP_ST || op == OP_RMW) begin fwd_v = 1'b1; fwd_addr = addr; fwd_data = ref_mem[addr]; end
`endif
        sb.push_back(e);
        bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd; bus.req_reg = rg;
        bus.req_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin @(negedge clk); waited++; end
        total++;
        if (!bus.req_ready) begin
            bad++;
            $display("FAIL accept_timeout got req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(output logic [DW-1:0] d, output logic [RW-1:0] r, output logic wb,
                           output logic er, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.resp_valid && lat < 20);
        total++;
        if (!bus.resp_valid) begin
            bad++;
            $display("FAIL resp_timeout got resp_valid=%b required 1", bus.resp_valid);
        end
        d = bus.resp_data; r = bus.resp_reg; wb = bus.resp_wb; er = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.resp_valid, M_re, M_we, M_add, M_wd, bus.resp_data, bus.resp_wb, bus.resp_err} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b re=%b we=%b add=%h wd=%h data=%h required rdy=1 others 0",
                     bus.req_ready, bus.resp_valid, M_re, M_we, M_add, M_wd, bus.resp_data);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b vld=%b required rdy=1 vld=0", bus.req_ready, bus.resp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int w, lat, re0;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        re0 = re_cnt;
        issue(OP_LD, 4'd2, 4'd0, 2'd1, w);
        collect(d, r, wb, er, lat);
        e = sb.pop_front();
        $display("load addr=2 data=%h reg=%0d wb=%b err=%b lat=%0d", d, r, wb, er, lat);
        total++;
        if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err} || d !== 4'd5) begin
            bad++;
            $display("FAIL load_resp got data=%h reg=%0d wb=%b err=%b required data=%h reg=%0d wb=%b err=%b",
                     d, r, wb, er, e.data, e.rg, e.wb, e.err);
        end
        total++;
        if (lat != e.lat) begin bad++; $display("FAIL load_latency got %0d required %0d", lat, e.lat); end
        total++;
        if (re_cnt - re0 != 1 || last_re_add !== 4'd2) begin
            bad++;
            $display("FAIL load_mre got pulses=%0d add=%h required pulses=1 add=2", re_cnt - re0, last_re_add);
        end
    endtask

    task automatic test_store_load();
        int w, lat, re0, we0;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        logic [1:0] ops [2];
        ops[0] = OP_ST; ops[1] = OP_LD;
        for (int k = 0; k < 2; k++) begin
            re0 = re_cnt; we0 = we_cnt;
            issue(ops[k], 4'd7, 4'hA, 2'(k + 2), w);
            collect(d, r, wb, er, lat);
            e = sb.pop_front();
            $display("%s addr=7 data=%h reg=%0d wb=%b lat=%0d", (k == 0) ? "store" : "load", d, r, wb, lat);
            total++;
            if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err}) begin
                bad++;
                $display("FAIL store_load_resp[%0d] got data=%h reg=%0d wb=%b err=%b required data=%h reg=%0d wb=%b err=%b",
                         k, d, r, wb, er, e.data, e.rg, e.wb, e.err);
            end
            total++;
            if (lat != e.lat || re_cnt - re0 != e.re || we_cnt - we0 != e.we) begin
                bad++;
                $display("FAIL store_load_timing[%0d] got lat=%0d re=%0d we=%0d required lat=%0d re=%0d we=%0d",
                         k, lat, re_cnt - re0, we_cnt - we0, e.lat, e.re, e.we);
            end
        end
        total++;
        if (last_we_add !== 4'd7 || last_we_wd !== 4'hA) begin
            bad++;
            $display("FAIL store_write got add=%h wd=%h required add=7 wd=a", last_we_add, last_we_wd);
        end
    endtask

    task automatic test_rmw();
        int w, lat, re0, we0;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        logic [1:0]    op_t [5];
        logic [AW-1:0] ad_t [5];
        logic [DW-1:0] wd_t [5];
        op_t[0] = OP_RMW; ad_t[0] = 4'd1;  wd_t[0] = 4'hF;
        op_t[1] = OP_LD;  ad_t[1] = 4'd1;  wd_t[1] = 4'h0;
        op_t[2] = OP_ST;  ad_t[2] = 4'd15; wd_t[2] = 4'hF;
        op_t[3] = OP_RMW; ad_t[3] = 4'd15; wd_t[3] = 4'h3;
        op_t[4] = OP_LD;  ad_t[4] = 4'd15; wd_t[4] = 4'h0;
        for (int k = 0; k < 5; k++) begin
            re0 = re_cnt; we0 = we_cnt;
            issue(op_t[k], ad_t[k], wd_t[k], 2'(k), w);
            collect(d, r, wb, er, lat);
            e = sb.pop_front();
            $display("rmw_seq[%0d] op=%0d addr=%0d data=%h wb=%b lat=%0d", k, op_t[k], ad_t[k], d, wb, lat);
            total++;
            if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err}) begin
                bad++;
                $display("FAIL rmw_resp[%0d] got data=%h reg=%0d wb=%b err=%b required data=%h reg=%0d wb=%b err=%b",
                         k, d, r, wb, er, e.data, e.rg, e.wb, e.err);
            end
            total++;
            if (lat != e.lat || re_cnt - re0 != e.re || we_cnt - we0 != e.we) begin
                bad++;
                $display("FAIL rmw_timing[%0d] got lat=%0d re=%0d we=%0d required lat=%0d re=%0d we=%0d",
                         k, lat, re_cnt - re0, we_cnt - we0, e.lat, e.re, e.we);
            end
            if (k == 0) begin
                total++;
                if (last_we_wd !== 4'h0 || d !== 4'h1) begin
                    bad++;
                    $display("FAIL rmw_wrap got wd=%h old=%h required wd=0 old=1", last_we_wd, d);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int w, lat, re0, we0;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        re0 = re_cnt; we0 = we_cnt;
        issue(OP_ILL, 4'd4, 4'h6, 2'd2, w);
        collect(d, r, wb, er, lat);
        e = sb.pop_front();
        $display("illegal data=%h reg=%0d wb=%b err=%b lat=%0d", d, r, wb, er, lat);
        total++;
        if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err} || er !== 1'b1) begin
            bad++;
            $display("FAIL illegal_resp got data=%h reg=%0d wb=%b err=%b required data=%h reg=%0d wb=%b err=1",
                     d, r, wb, er, e.data, e.rg, e.wb);
        end
        total++;
        if (lat != 1 || re_cnt != re0 || we_cnt != we0) begin
            bad++;
            $display("FAIL illegal_timing got lat=%0d re=%0d we=%0d required lat=1 re=0 we=0", lat, re_cnt - re0, we_cnt - we0);
        end
    endtask

    task automatic test_backpressure();
        int w, lat, re0;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        issue(OP_LD, 4'd2, 4'd0, 2'd3, w);
        e = sb.pop_front();
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.resp_valid && lat < 20);
        d = bus.resp_data; r = bus.resp_reg; wb = bus.resp_wb; er = bus.resp_err;
        $display("backpressure load data=%h reg=%0d lat=%0d", d, r, lat);
        total++;
        if ({bus.resp_valid, d, r, wb, er} !== {1'b1, e.data, e.rg, e.wb, e.err} || lat != e.lat) begin
            bad++;
            $display("FAIL bp_resp got vld=%b data=%h reg=%0d wb=%b lat=%0d required data=%h reg=%0d wb=%b lat=%0d",
                     bus.resp_valid, d, r, wb, lat, e.data, e.rg, e.wb, e.lat);
        end
        bus.req_op = OP_LD; bus.req_addr = 4'd1; bus.req_wdata = '0; bus.req_reg = 2'd0;
        bus.req_valid = 1'b1;
        re0 = re_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_reg, bus.resp_wb, bus.resp_err, bus.req_ready} !== {1'b1, d, r, wb, er, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got vld=%b data=%h reg=%0d rdy=%b required vld=1 data=%h reg=%0d rdy=0",
                         i, bus.resp_valid, bus.resp_data, bus.resp_reg, bus.req_ready, d, r);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        total++;
        if (re_cnt != re0) begin bad++; $display("FAIL bp_busy_accept got re pulses=%0d required 0", re_cnt - re0); end
        issue(OP_LD, 4'd1, 4'd0, 2'd0, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL bp_idle_gap got wait=%0d required 0", w); end
        collect(d, r, wb, er, lat);
        e = sb.pop_front();
        $display("post-bp load addr=1 data=%h lat=%0d", d, lat);
        total++;
        if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err} || lat != e.lat) begin
            bad++;
            $display("FAIL bp_next got data=%h reg=%0d lat=%0d required data=%h reg=%0d lat=%0d", d, r, lat, e.data, e.rg, e.lat);
        end
    endtask

    task automatic test_reset_mid_op();
        int w, lat;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        exp_t e;
        issue(OP_LD, 4'd3, 4'd0, 2'd2, w);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL midreset_idle[%0d] got vld=%b rdy=%b required vld=0 rdy=1", i, bus.resp_valid, bus.req_ready);
            end
        end
        @(posedge clk); #1;
        issue(OP_LD, 4'd2, 4'd0, 2'd1, w);
        collect(d, r, wb, er, lat);
        e = sb.pop_front();
        $display("post-reset load addr=2 data=%h lat=%0d", d, lat);
        total++;
        if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err} || d !== 4'd5 || lat != e.lat) begin
            bad++;
            $display("FAIL midreset_load got data=%h reg=%0d lat=%0d required data=5 reg=%0d lat=%0d", d, r, lat, e.rg, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int w, lat;
        logic [DW-1:0] d; logic [RW-1:0] r; logic wb, er;
        logic [1:0] op;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            op = 2'($urandom_range(0, 3));
            issue(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
            collect(d, r, wb, er, lat);
            e = sb.pop_front();
            $display("b2b[%0d] op=%0d data=%h reg=%0d wb=%b err=%b lat=%0d wait=%0d", k, op, d, r, wb, er, lat, w);
            total++;
            if ({d, r, wb, er} !== {e.data, e.rg, e.wb, e.err} || lat != e.lat || w != 0) begin
                bad++;
                $display("FAIL b2b[%0d] got data=%h reg=%0d wb=%b err=%b lat=%0d wait=%0d required data=%h reg=%0d wb=%b err=%b lat=%0d wait=0",
                         k, d, r, wb, er, lat, w, e.data, e.rg, e.wb, e.err, e.lat);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_reg = '0; bus.resp_ready = 1'b0;
        model_reset();
        test_reset();
        test_load();
        test_store_load();
        test_rmw();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
